cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_pkg.sv | 18 +
 rtl/nzcv_calc.sv | 23 ++
 rtl/cmp_arbiter.sv | 134 +++++++++++++
 tb/tb_cmp_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the compare arbiter.
package cmp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Bit positions inside the {N,Z,C,V} condition register
    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/nzcv_calc.sv
// Derives the NZCV condition flags of a subtraction a - b.
module nzcv_calc
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_diff,
    input  logic             i_carry,
    output logic [3:0]       o_flags
);

    // Flags from the subtraction result; carry set means no borrow (a >= b unsigned)
    always_comb begin
        o_flags        = 4'b0000;
        o_flags[N_BIT] = i_diff[WIDTH-1];
        o_flags[Z_BIT] = (i_diff == '0);
        o_flags[C_BIT] = i_carry;
        o_flags[V_BIT] = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (i_diff[WIDTH-1] != i_a[WIDTH-1]);
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin compare unit: grant, execute A-B, write back flags.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Req0,
    input  logic                    Req1,
    input  logic signed [WIDTH-1:0] A0,
    input  logic signed [WIDTH-1:0] B0,
    input  logic signed [WIDTH-1:0] A1,
    input  logic signed [WIDTH-1:0] B1,
    input  logic                    S0,
    input  logic                    S1,
    input  logic                    Flag_Wr_En,
    input  logic [3:0]              Flag_Wr_Data,
    output logic                    Gnt0,
    output logic                    Gnt1,
    output logic                    Done0,
    output logic                    Done1,
    output logic [WIDTH-1:0]        Result,
    output logic [3:0]              Flag,
    output logic                    Busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_s;
    logic             r_id;
    logic             r_last;

    logic             w_can_grant;
    logic             w_gnt0;
    logic             w_gnt1;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_carry;
    logic [3:0]       w_flags;

    // Round-robin pick: on contention the requester not granted last wins
    assign w_can_grant = (r_state == ST_IDLE) || (r_state == ST_WB);
    assign w_gnt0      = w_can_grant & Req0 & (~Req1 | r_last);
    assign w_gnt1      = w_can_grant & Req1 & (~Req0 | ~r_last);

    // Subtract as A + ~B + 1 one bit wider so the top bit is the carry out
    assign w_sum   = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_diff  = w_sum[WIDTH-1:0];
    assign w_carry = w_sum[WIDTH];

    nzcv_calc #(
        .WIDTH (WIDTH)
    ) u_nzcv (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_diff  (w_diff),
        .i_carry (w_carry),
        .o_flags (w_flags)
    );

    // Control FSM with operand capture, result/flag writeback and pulse outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            Gnt0    <= 1'b0;
            Gnt1    <= 1'b0;
            Done0   <= 1'b0;
            Done1   <= 1'b0;
            Result  <= '0;
            Flag    <= 4'b0000;
            Busy    <= 1'b0;
        end else begin
            Gnt0  <= w_gnt0;
            Gnt1  <= w_gnt1;
            Done0 <= 1'b0;
            Done1 <= 1'b0;

            if (w_gnt0 || w_gnt1) begin
                r_id   <= w_gnt1;
                r_last <= w_gnt1;
                r_a    <= w_gnt1 ? A1 : A0;
                r_b    <= w_gnt1 ? B1 : B0;
                r_s    <= w_gnt1 ? S1 : S0;
            end

            // External load; a same-edge compare update below overrides it
            if (Flag_Wr_En) begin
                Flag <= Flag_Wr_Data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_state <= ST_EXEC;
                        Busy    <= 1'b1;
                    end else begin
                        Busy    <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    Result  <= w_diff;
                    if (r_s) begin
                        Flag <= w_flags;
                    end
                    r_state <= ST_WB;
                    Busy    <= 1'b1;
                end
                ST_WB: begin
                    Done0 <= ~r_id;
                    Done1 <= r_id;
                    if (w_gnt0 || w_gnt1) begin
                        r_state <= ST_EXEC;
                        Busy    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        Busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed self-checking bench for cmp_arbiter.
module tb_cmp_arbiter;

    localparam int unsigned WIDTH = 32;

    logic                    Clk;
    logic                    Rst_n;
    logic                    Req0;
    logic                    Req1;
    logic signed [WIDTH-1:0] A0;
    logic signed [WIDTH-1:0] B0;
    logic signed [WIDTH-1:0] A1;
    logic signed [WIDTH-1:0] B1;
    logic                    S0;
    logic                    S1;
    logic                    Flag_Wr_En;
    logic [3:0]              Flag_Wr_Data;
    logic                    Gnt0;
    logic                    Gnt1;
    logic                    Done0;
    logic                    Done1;
    logic [WIDTH-1:0]        Result;
    logic [3:0]              Flag;
    logic                    Busy;

    int errors = 0;
    int checks = 0;

    cmp_arbiter #(
        .WIDTH (WIDTH)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Req0         (Req0),
        .Req1         (Req1),
        .A0           (A0),
        .B0           (B0),
        .A1           (A1),
        .B1           (B1),
        .S0           (S0),
        .S1           (S1),
        .Flag_Wr_En   (Flag_Wr_En),
        .Flag_Wr_Data (Flag_Wr_Data),
        .Gnt0         (Gnt0),
        .Gnt1         (Gnt1),
        .Done0        (Done0),
        .Done1        (Done1),
        .Result       (Result),
        .Flag         (Flag),
        .Busy         (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst_n = 1'b0;
        tick();
        tick();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0; S0 = 1'b0; S1 = 1'b0;
        Flag_Wr_En = 1'b0; Flag_Wr_Data = 4'b0000;
        #2;
        checks++;
        if ({Gnt1, Gnt0, Done1, Done0, Busy} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {Gnt1, Gnt0, Done1, Done0, Busy});
        end
        checks++;
        if (Result !== 32'h0 || Flag !== 4'b0000) begin
            errors++;
            $display("FAIL reset_data: got result=%h flag=%b want 0/0000", Result, Flag);
        end
        apply_reset();
    endtask

    // Req0 5-5 with S=1; Gnt at t, Done at t+2
    task automatic test_single();
        A0 = 32'd5; B0 = 32'd5; S0 = 1'b1; Req0 = 1'b1;
        tick();
        checks++;
        if ({Gnt1, Gnt0, Busy} !== 3'b011) begin
            errors++;
            $display("FAIL single_gnt: got gnt1,gnt0,busy=%b want 011", {Gnt1, Gnt0, Busy});
        end
        Req0 = 1'b0;
        tick();
        checks++;
        if ({Gnt0, Done0, Busy} !== 3'b001) begin
            errors++;
            $display("FAIL single_wb: got gnt0,done0,busy=%b want 001", {Gnt0, Done0, Busy});
        end
        tick();
        checks++;
        if ({Done1, Done0} !== 2'b01) begin
            errors++;
            $display("FAIL single_done: got %b want 01", {Done1, Done0});
        end
        checks++;
        if (Result !== 32'h0 || Flag !== 4'b0110) begin
            errors++;
            $display("FAIL single_data: got result=%h flag=%b want 00000000/0110", Result, Flag);
        end
        tick();
        checks++;
        if (Done0 !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got done0=%b busy=%b want 0/0", Done0, Busy);
        end
    endtask

    // 7FFFFFFF - FFFFFFFF overflows into the sign bit
    task automatic test_overflow();
        A1 = 32'h7FFF_FFFF; B1 = 32'hFFFF_FFFF; S1 = 1'b1; Req1 = 1'b1;
        tick();
        checks++;
        if ({Gnt1, Gnt0} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_gnt: got %b want 10", {Gnt1, Gnt0});
        end
        Req1 = 1'b0;
        tick();
        tick();
        checks++;
        if ({Done1, Done0} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_done: got %b want 10", {Done1, Done0});
        end
        checks++;
        if (Result !== 32'h8000_0000 || Flag !== 4'b1001) begin
            errors++;
            $display("FAIL ovf_data: got result=%h flag=%b want 80000000/1001", Result, Flag);
        end
        S1 = 1'b0;
    endtask

    // Both requests held: grants alternate 0,1,0,1 every other cycle
    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        logic [1:0] exp_done;
        apply_reset();
        A0 = '0; B0 = '0; A1 = '0; B1 = '0; S0 = 1'b0; S1 = 1'b0;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) begin
                Req0 = 1'b0; Req1 = 1'b0;
            end
            exp_gnt  = (k % 2 == 0) ? 2'b00 : ((k % 4 == 1) ? 2'b01 : 2'b10);
            exp_done = (k == 3 || k == 7) ? 2'b01 : ((k == 5) ? 2'b10 : 2'b00);
            checks++;
            if ({Gnt1, Gnt0} !== exp_gnt || {Done1, Done0} !== exp_done || Busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got gnt=%b done=%b busy=%b want gnt=%b done=%b busy=1",
                         k, {Gnt1, Gnt0}, {Done1, Done0}, Busy, exp_gnt, exp_done);
            end
        end
        tick();
        checks++;
        if ({Done1, Done0} !== 2'b10 || Busy !== 1'b0 || {Gnt1, Gnt0} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_drain: got done=%b busy=%b gnt=%b want 10/0/00",
                     {Done1, Done0}, Busy, {Gnt1, Gnt0});
        end
    endtask

    // Preload flags, collide external write with S=1 update, then S=0 holds
    task automatic test_flag_collision();
        Flag_Wr_En = 1'b1; Flag_Wr_Data = 4'b1111;
        tick();
        Flag_Wr_En = 1'b0;
        checks++;
        if (Flag !== 4'b1111) begin
            errors++;
            $display("FAIL flag_preload: got %b want 1111", Flag);
        end
        A0 = 32'd3; B0 = 32'd7; S0 = 1'b1; Req0 = 1'b1;
        tick();
        Req0 = 1'b0;
        Flag_Wr_En = 1'b1; Flag_Wr_Data = 4'b0000;
        tick();
        Flag_Wr_En = 1'b0;
        checks++;
        if (Flag !== 4'b1000 || Result !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL flag_collide: got flag=%b result=%h want 1000/fffffffc", Flag, Result);
        end
        tick();
        A0 = 32'd5; B0 = 32'd5; S0 = 1'b0; Req0 = 1'b1;
        tick();
        Req0 = 1'b0;
        tick();
        tick();
        checks++;
        if (Done0 !== 1'b1 || Flag !== 4'b1000 || Result !== 32'h0) begin
            errors++;
            $display("FAIL flag_hold: got done0=%b flag=%b result=%h want 1/1000/00000000",
                     Done0, Flag, Result);
        end
    endtask

    // Reset in EXEC clears outputs at once and drops the in-flight compare
    task automatic test_reset_midop();
        A0 = 32'd9; B0 = 32'd2; S0 = 1'b1; Req0 = 1'b1;
        tick();
        Req0 = 1'b0;
        checks++;
        if (Gnt0 !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_gnt: got gnt0=%b busy=%b want 1/1", Gnt0, Busy);
        end
        #1;
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({Gnt1, Gnt0, Done1, Done0, Busy} !== 5'b00000 || Result !== 32'h0 || Flag !== 4'b0000) begin
            errors++;
            $display("FAIL midop_async: got ctrl=%b result=%h flag=%b want 00000/0/0000",
                     {Gnt1, Gnt0, Done1, Done0, Busy}, Result, Flag);
        end
        tick();
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({Done1, Done0} !== 2'b00 || Flag !== 4'b0000 || Result !== 32'h0) begin
                errors++;
                $display("FAIL midop_nodone%0d: got done=%b flag=%b result=%h want 00/0000/0",
                         k, {Done1, Done0}, Flag, Result);
            end
        end
        A1 = 32'd1; B1 = 32'd1; S1 = 1'b0; Req1 = 1'b1;
        tick();
        Req1 = 1'b0;
        checks++;
        if ({Gnt1, Gnt0} !== 2'b10) begin
            errors++;
            $display("FAIL midop_regrant: got %b want 10", {Gnt1, Gnt0});
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_flag_collision();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // One-hot safety on the pulse outputs
    always @(negedge Clk) begin
        if (Rst_n && ((Gnt0 && Gnt1) || (Done0 && Done1))) begin
            checks++;
            errors++;
            $display("FAIL onehot: got gnt=%b done=%b want not both high", {Gnt1, Gnt0}, {Done1, Done0});
        end
    end

endmodule
